// File: rtl/board_tx_pkg.sv
// Shared types and constants for the board snapshot serial transmitter.
// Parity support is selected with the BOARD_TX_PARITY_EN macro.
package board_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int BOARD_W_DEF      = 32;
  localparam int FRAME_BITS_NOPAR = BOARD_W_DEF + 2;
  localparam int FRAME_BITS_PAR   = BOARD_W_DEF + 3;
  localparam int BIT_IDX_W        = $clog2(BOARD_W_DEF);

endpackage

// File: rtl/board_tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and strobes o_tc on the last
// count. A synchronous clear parks it at 0 so a new bit period starts cleanly.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic i_clk,
  input  logic i_clr,
  output logic o_tc
);

  logic [7:0] r_cnt;

  assign o_tc = (r_cnt == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge i_clk) begin
    if (i_clr)     r_cnt <= '0;
    else if (o_tc) r_cnt <= '0;
    else           r_cnt <= r_cnt + 8'd1;
  end

endmodule

// File: rtl/board_tx.sv
// Serial transmitter for the board snapshot: start bit, data MSB first, optional
// odd parity (BOARD_TX_PARITY_EN), stop bit. All outputs are registered.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a load request
// ST_START  | driving the start bit (low)
// ST_DATA   | driving shift-register MSB, one bit per timer period
// ST_PARITY | driving odd parity of the captured word
// ST_STOP   | driving the stop bit (high)
module board_tx
  import board_tx_pkg::*;
#(
  parameter int BOARD_W      = BOARD_W_DEF,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               i_clka,
  input  logic               i_restart,
  input  logic               i_load,
  input  logic [BOARD_W-1:0] i_board_in,
  output logic               o_tx_out,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_overrun
);

  localparam int IDX_W = $clog2(BOARD_W);

  tx_state_e          r_state;
  logic [BOARD_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               r_tx;
  logic               r_busy;
  logic               r_done;
  logic               r_overrun;
`ifdef BOARD_TX_PARITY_EN
  logic               r_parity;
`endif
  logic               w_tc;
  logic               w_timer_clr;

  // The timer idles at 0 so the first START cycle is count 0.
  assign w_timer_clr = i_restart | (r_state == ST_IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .i_clk (i_clka),
    .i_clr (w_timer_clr),
    .o_tc  (w_tc)
  );

  always_ff @(posedge i_clka) begin
    if (i_restart) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
`ifdef BOARD_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_load && r_busy) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_shift   <= i_board_in;
            r_bit_idx <= '0;
            r_state   <= ST_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
`ifdef BOARD_TX_PARITY_EN
            r_parity  <= ~^i_board_in;
`endif
          end
        end
        ST_START: begin
          if (w_tc) begin
            r_state <= ST_DATA;
            r_tx    <= r_shift[BOARD_W-1];
          end
        end
        ST_DATA: begin
          // tx is registered, so the bit following the shift is read at [W-2].
          if (w_tc) begin
            r_shift <= r_shift << 1;
            if (r_bit_idx == IDX_W'(BOARD_W - 1)) begin
`ifdef BOARD_TX_PARITY_EN
              r_state <= ST_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[BOARD_W-2];
            end
          end
        end
`ifdef BOARD_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tc) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_tc) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_out     = r_tx;
  assign o_busy       = r_busy;
  assign o_frame_done = r_done;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_board_tx.sv
// Bench for board_tx: a queue-based frame model checked every cycle, plus
// directed frames with hand-computed serial contents.
module tb_board_tx;
  import board_tx_pkg::*;

  localparam int CPB = 2;
`ifdef BOARD_TX_PARITY_EN
  localparam int NBITS     = FRAME_BITS_PAR;
  localparam int FRAME_CYC = 70;
`else
  localparam int NBITS     = FRAME_BITS_NOPAR;
  localparam int FRAME_CYC = 68;
`endif

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        load = 1'b0;
  logic [31:0] board_in = '0;
  logic        o_tx, o_busy, o_done, o_over;

  int total = 0;
  int bad = 0;

  board_tx #(.BOARD_W(32), .CLKS_PER_BIT(CPB)) dut (
    .i_clka       (clka),
    .i_restart    (restart),
    .i_load       (load),
    .i_board_in   (board_in),
    .o_tx_out     (o_tx),
    .o_busy       (o_busy),
    .o_frame_done (o_done),
    .o_overrun    (o_over)
  );

  always #5 clka = ~clka;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a list of line levels, one per clock cycle.
  bit   m_q[$];
  logic m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_over = 1'b0;
  bit   m_valid = 1'b0;

  function automatic void push_frame(input logic [31:0] w);
    bit lvl[$];
    lvl.push_back(1'b0);
    for (int i = 31; i >= 0; i--) lvl.push_back(w[i]);
`ifdef BOARD_TX_PARITY_EN
    lvl.push_back(($countones(w) % 2) == 0);
`endif
    lvl.push_back(1'b1);
    foreach (lvl[k]) repeat (CPB) m_q.push_back(lvl[k]);
  endfunction

  always @(posedge clka) begin
    if (restart) begin
      m_q.delete();
      m_tx = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_over = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (load && m_busy) m_over = 1'b1;
      if (load && !m_busy) push_frame(board_in);
      if (m_q.size() > 0) begin
        m_tx = m_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_done = m_busy;
        m_busy = 1'b0;
        m_tx = 1'b1;
      end
    end
  end

  always @(negedge clka) begin
    if (m_valid) begin
      check("cyc_tx", o_tx, m_tx);
      check("cyc_busy", o_busy, m_busy);
      check("cyc_done", o_done, m_done);
      check("cyc_overrun", o_over, m_over);
    end
  end

  logic s_tx [0:127];
  int   s_busy, s_done;

  // Sends one frame; index 0 of s_tx is the first cycle after the load edge.
  task automatic run_frame(input logic [31:0] w, input int inj_at, input int ncyc);
    @(negedge clka); board_in = w; load = 1'b1;
    @(negedge clka); load = 1'b0;
    s_busy = 0; s_done = 0;
    for (int i = 0; i < ncyc; i++) begin
      s_tx[i] = o_tx;
      if (o_busy) s_busy++;
      if (o_done) s_done++;
      if (i == inj_at) begin load = 1'b1; board_in = 32'hFFFF_FFFF; end
      else load = 1'b0;
      @(negedge clka);
    end
  endtask

  function automatic logic [31:0] decode();
    logic [31:0] w;
    for (int b = 0; b < 32; b++) w[31-b] = s_tx[CPB + CPB*b];
    return w;
  endfunction

  initial begin
    int  d;
    bit  found;
    restart = 1'b1; load = 1'b1; board_in = 32'hFFFF_FFFF;
    @(negedge clka); @(negedge clka);
    restart = 1'b0; load = 1'b0; board_in = '0;
    repeat (8) @(negedge clka);
    check("reset_busy", o_busy, 1'b0);
    check("reset_tx", o_tx, 1'b1);
    check("reset_overrun", o_over, 1'b0);

    run_frame(32'hA5A5_0F0F, -1, FRAME_CYC + 4);
    check("basic_start0", s_tx[0], 1'b0);
    check("basic_start1", s_tx[1], 1'b0);
    check("basic_bit0", s_tx[2], 1'b1);
    check("basic_bit1", s_tx[4], 1'b0);
    check("basic_word", decode(), 32'hA5A5_0F0F);
    check("basic_stop", s_tx[FRAME_CYC-1], 1'b1);
    check("basic_busy_len", s_busy, FRAME_CYC);
    check("basic_done_cnt", s_done, 1);

`ifdef BOARD_TX_PARITY_EN
    run_frame(32'h0000_0001, -1, FRAME_CYC + 4);
    check("par_one", s_tx[66], 1'b0);
    check("par_busy_len", s_busy, 70);
    run_frame(32'h0000_0000, -1, FRAME_CYC + 4);
    check("par_zero", s_tx[66], 1'b1);
`endif

    run_frame(32'h1234_5678, 22, FRAME_CYC + 4);
    check("ovr_word", decode(), 32'h1234_5678);
    check("ovr_set", o_over, 1'b1);
    repeat (5) @(negedge clka);
    check("ovr_sticky", o_over, 1'b1);
    restart = 1'b1;
    @(negedge clka);
    restart = 1'b0;
    check("ovr_cleared", o_over, 1'b0);

    @(negedge clka); board_in = 32'h0000_FFFF; load = 1'b1;
    @(negedge clka); load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (o_done) found = 1'b1;
      else @(negedge clka);
    end
    check("b2b_done_seen", found, 1'b1);
    load = 1'b1;
    @(negedge clka); load = 1'b0;
    check("b2b_start_tx", o_tx, 1'b0);
    check("b2b_start_busy", o_busy, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (o_done) found = 1'b1;
      else @(negedge clka);
    end
    check("b2b_second_done", found, 1'b1);
    check("b2b_no_overrun", o_over, 1'b0);

    @(negedge clka); board_in = 32'hA5A5_0F0F; load = 1'b1;
    @(negedge clka); load = 1'b0;
    repeat (20) @(negedge clka);
    restart = 1'b1;
    @(negedge clka);
    restart = 1'b0;
    check("mid_tx", o_tx, 1'b1);
    check("mid_busy", o_busy, 1'b0);
    d = 0;
    repeat (80) begin
      if (o_done) d++;
      @(negedge clka);
    end
    check("mid_no_done", d, 0);
    run_frame(32'h3C3C_3C3C, -1, FRAME_CYC + 4);
    check("mid_next_word", decode(), 32'h3C3C_3C3C);
    check("mid_next_busy", s_busy, NBITS * CPB);
    check("mid_next_done", s_done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
